// File: rtl/data_frame_parser.sv
// Receive-side frame parser: strips header/footer from the 64-bit framed stream,
// forwards data words with a last marker and reports per-frame info and errors.
module data_frame_parser #(
  parameter int DOUT_WIDTH       = 64,
  parameter int MAX_FRAME_LENGTH = 200,
  parameter int FRAME_LEN_WIDTH  = 10,
  parameter int FRAME_CNT_WIDTH  = 16
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic                       iVALID,
  input  logic [DOUT_WIDTH-1:0]      DIN,
  output logic                       oREADY,
  output logic                       oVALID,
  output logic [DOUT_WIDTH-1:0]      DOUT,
  output logic                       DOUT_LAST,
  input  logic                       iREADY,
  output logic                       INFO_VALID,
  output logic [3:0]                 CH_ID,
  output logic [47:0]                TIME_STAMP,
  output logic [11:0]                BASELINE,
  output logic [12:0]                THRESHOLD,
  output logic [FRAME_LEN_WIDTH-1:0] FRAME_LEN,
  output logic                       ERR_NO_HEADER,
  output logic                       ERR_LEN,
  output logic                       ERR_FOOTER,
  output logic [FRAME_CNT_WIDTH-1:0] FRAME_CNT
);

  localparam int unsigned MAX_EVEN = 2 * (MAX_FRAME_LENGTH / 2);

  typedef enum logic [1:0] {IDLE, DATA, FOOTER} state_t;

  state_t                     state, state_n;
  logic [FRAME_LEN_WIDTH-1:0] cnt, len_hdr, len_in;
  logic [3:0]                 ch_hdr;
  logic [23:0]                ts_hdr;
  logic acc, is_hdr, len_ok, foot_ok;
  logic hdr_load, load, info_load, err_nh_n, err_len_n, err_ft_n;

  // Only the DATA state can be throttled by the single output register.
  assign oREADY  = RESETN & ((state != DATA) | ~oVALID | iREADY);
  assign acc     = iVALID & oREADY;
  assign len_in  = DIN[FRAME_LEN_WIDTH-1:0];
  assign is_hdr  = (DIN[63:56] == 8'hFF);
  assign len_ok  = (len_in != '0) && !len_in[0] && (32'(len_in) <= MAX_EVEN);
  assign foot_ok = (DIN[7:0] == 8'h0F) && (DIN[63:60] == 4'hF) && (DIN[47:45] == 3'b111);

  always_comb begin
    state_n   = state;
    hdr_load  = 1'b0;
    load      = 1'b0;
    info_load = 1'b0;
    err_nh_n  = 1'b0;
    err_len_n = 1'b0;
    err_ft_n  = 1'b0;
    case (state)
      IDLE: if (acc) begin
        if (is_hdr) begin
          hdr_load = 1'b1;
          if (len_ok) state_n = DATA;
          else        err_len_n = 1'b1;
        end else begin
          err_nh_n = 1'b1;
        end
      end
      DATA: if (acc) begin
        load = 1'b1;
        if (cnt == FRAME_LEN_WIDTH'(1)) state_n = FOOTER;
      end
      FOOTER: if (acc) begin
        state_n = IDLE;
        if (foot_ok) info_load = 1'b1;
        else         err_ft_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state         <= IDLE;
      cnt           <= '0;
      len_hdr       <= '0;
      ch_hdr        <= '0;
      ts_hdr        <= '0;
      oVALID        <= 1'b0;
      DOUT          <= '1;
      DOUT_LAST     <= 1'b0;
      INFO_VALID    <= 1'b0;
      ERR_NO_HEADER <= 1'b0;
      ERR_LEN       <= 1'b0;
      ERR_FOOTER    <= 1'b0;
      CH_ID         <= '0;
      TIME_STAMP    <= '0;
      BASELINE      <= '0;
      THRESHOLD     <= '0;
      FRAME_LEN     <= '0;
      FRAME_CNT     <= '0;
    end else begin
      state <= state_n;
      if (hdr_load) begin
        ch_hdr  <= DIN[55:52];
        ts_hdr  <= DIN[51:28];
        len_hdr <= len_in;
        cnt     <= len_in;
      end else if (load) begin
        cnt <= cnt - 1'b1;
      end
      // Drain and load may coincide; a load always wins the register.
      if (load) begin
        DOUT      <= DIN;
        DOUT_LAST <= (cnt == FRAME_LEN_WIDTH'(1));
      end
      oVALID        <= load | (oVALID & ~iREADY);
      INFO_VALID    <= info_load;
      ERR_NO_HEADER <= err_nh_n;
      ERR_LEN       <= err_len_n;
      ERR_FOOTER    <= err_ft_n;
      if (info_load) begin
        CH_ID      <= ch_hdr;
        TIME_STAMP <= {DIN[31:8], ts_hdr};
        BASELINE   <= DIN[59:48];
        THRESHOLD  <= DIN[44:32];
        FRAME_LEN  <= len_hdr;
        FRAME_CNT  <= FRAME_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_frame_parser.sv
// Directed bench for data_frame_parser: nominal, backpressure, bad footer,
// length errors, garbage words, max frame and mid-frame reset.
module tb_data_frame_parser;

  logic        CLK = 1'b0, RESETN = 1'b0, iVALID = 1'b0, iREADY = 1'b1;
  logic [63:0] DIN = '0;
  logic        oREADY, oVALID, DOUT_LAST, INFO_VALID;
  logic [63:0] DOUT;
  logic [3:0]  CH_ID;
  logic [47:0] TIME_STAMP;
  logic [11:0] BASELINE;
  logic [12:0] THRESHOLD;
  logic [9:0]  FRAME_LEN;
  logic        ERR_NO_HEADER, ERR_LEN, ERR_FOOTER;
  logic [15:0] FRAME_CNT;

  int tests = 0, fails = 0;
  logic [64:0] outq[$];
  bit bp_mode = 0, chk_bp = 0;

  data_frame_parser dut (
    .CLK(CLK), .RESETN(RESETN), .iVALID(iVALID), .DIN(DIN), .oREADY(oREADY),
    .oVALID(oVALID), .DOUT(DOUT), .DOUT_LAST(DOUT_LAST), .iREADY(iREADY),
    .INFO_VALID(INFO_VALID), .CH_ID(CH_ID), .TIME_STAMP(TIME_STAMP),
    .BASELINE(BASELINE), .THRESHOLD(THRESHOLD), .FRAME_LEN(FRAME_LEN),
    .ERR_NO_HEADER(ERR_NO_HEADER), .ERR_LEN(ERR_LEN), .ERR_FOOTER(ERR_FOOTER),
    .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [3:0] ch, input logic [23:0] ts,
                                         input logic [9:0] len);
    return {8'hFF, ch, ts, 18'h0, len};
  endfunction

  function automatic logic [63:0] mk_ftr(input logic [11:0] bl, input logic [12:0] th,
                                         input logic [23:0] ts, input logic [7:0] lo);
    return {4'hF, bl, 3'b111, th, ts, lo};
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that accepted the word.
  task automatic send(input logic [63:0] w);
    int n = 0;
    iVALID = 1'b1;
    DIN    = w;
    @(negedge CLK);
    while (!oREADY && n < 100) begin
      n++;
      @(negedge CLK);
    end
    if (!oREADY) begin
      tests++;
      fails++;
      $error("FAIL send_timeout observed=oREADY_low expected=accept word=%h", w);
    end
    @(posedge CLK);
    #1;
    iVALID = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] h, input logic [63:0] base, input int len,
                            input logic [63:0] f);
    send(h);
    chk_bp = bp_mode;
    for (int i = 0; i < len; i++) send(base + 64'(i));
    chk_bp = 0;
    send(f);
  endtask

  task automatic expect_info(input logic [3:0] ch, input logic [47:0] ts, input logic [11:0] bl,
                             input logic [12:0] th, input logic [9:0] len, input logic [15:0] cnt);
    @(negedge CLK);
    chk("info_valid_hi", INFO_VALID, 1);
    chk("ch_id", CH_ID, ch);
    chk("time_stamp", TIME_STAMP, ts);
    chk("baseline", BASELINE, bl);
    chk("threshold", THRESHOLD, th);
    chk("frame_len", FRAME_LEN, len);
    chk("frame_cnt", FRAME_CNT, cnt);
    @(negedge CLK);
    chk("info_valid_lo", INFO_VALID, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (oVALID && n < 50) begin
      n++;
      @(negedge CLK);
    end
    chk("drain_timeout", oVALID, 0);
  endtask

  task automatic check_out(input logic [63:0] base, input int len);
    chk("word_count", 65'(outq.size()), 65'(len));
    for (int i = 0; i < len && i < outq.size(); i++)
      chk($sformatf("word%0d", i), outq[i], {(i == len - 1), base + 64'(i)});
    outq.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_ovalid", oVALID, 0);
    chk("rst_dout", DOUT, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_last", DOUT_LAST, 0);
    chk("rst_info", INFO_VALID, 0);
    chk("rst_errs", {ERR_NO_HEADER, ERR_LEN, ERR_FOOTER}, 0);
    chk("rst_ch", CH_ID, 0);
    chk("rst_ts", TIME_STAMP, 0);
    chk("rst_bl_th", {BASELINE, THRESHOLD}, 0);
    chk("rst_len", FRAME_LEN, 0);
    chk("rst_cnt", FRAME_CNT, 0);
  endtask

  // Downstream ready: constant 1, or the 1,0,0,1 pattern in backpressure mode.
  initial begin
    int ph = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (bp_mode) begin
        iREADY = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        iREADY = 1'b1;
        ph = 0;
      end
    end
  end

  // Output monitor: captures transfers and checks stall behaviour.
  initial begin
    logic        stall = 1'b0;
    logic [63:0] pd = '0;
    forever begin
      @(negedge CLK);
      if (RESETN && stall) begin
        chk("dout_stable", DOUT, pd);
        chk("ovalid_hold", oVALID, 1);
      end
      if (chk_bp && oVALID && !iREADY) chk("oready_bp", oREADY, 0);
      stall = RESETN && oVALID && !iREADY;
      pd    = DOUT;
      if (RESETN && oVALID && iREADY) outq.push_back({DOUT_LAST, DOUT});
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ftr_nom;
    logic [9:0]  bad_len[3];
    logic [63:0] junk[3];
    ftr_nom = mk_ftr(12'hABC, 13'h1FFF, 24'h654321, 8'h0F);
    bad_len[0] = 10'd0; bad_len[1] = 10'd3; bad_len[2] = 10'd202;
    junk[0] = 64'h0000_0000_0000_0004;
    junk[1] = 64'hFE12_3456_7800_0004;
    junk[2] = 64'h7FFF_FFFF_FFFF_FFFF;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_oready", oREADY, 0);
    check_reset_vals();
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    @(posedge CLK);
    #1;

    // Nominal frame; the first data word carries an FF top byte on purpose
    send_frame(mk_hdr(4'h3, 24'h123456, 10'd4), 64'hFF11_2233_4455_6600, 4, ftr_nom);
    expect_info(4'h3, 48'h654321_123456, 12'hABC, 13'h1FFF, 10'd4, 16'd1);
    drain();
    check_out(64'hFF11_2233_4455_6600, 4);
    @(posedge CLK); #1;

    // Backpressure
    bp_mode = 1;
    send_frame(mk_hdr(4'h3, 24'h123456, 10'd4), 64'h0123_4567_89AB_0000, 4, ftr_nom);
    expect_info(4'h3, 48'h654321_123456, 12'hABC, 13'h1FFF, 10'd4, 16'd2);
    drain();
    bp_mode = 0;
    check_out(64'h0123_4567_89AB_0000, 4);
    @(posedge CLK); #1;

    // Bad footer, then a good frame
    send_frame(mk_hdr(4'h5, 24'hABCDEF, 10'd2), 64'h3333_0000_0000_0000, 2,
               mk_ftr(12'h123, 13'h0AA, 24'h111111, 8'h0E));
    @(negedge CLK);
    chk("err_footer_hi", ERR_FOOTER, 1);
    chk("bad_info", INFO_VALID, 0);
    chk("bad_cnt", FRAME_CNT, 2);
    chk("bad_ch_kept", CH_ID, 3);
    @(negedge CLK);
    chk("err_footer_lo", ERR_FOOTER, 0);
    drain();
    check_out(64'h3333_0000_0000_0000, 2);
    @(posedge CLK); #1;
    send_frame(mk_hdr(4'h5, 24'hABCDEF, 10'd2), 64'h4444_0000_0000_0010, 2,
               mk_ftr(12'h123, 13'h0AA, 24'h111111, 8'h0F));
    expect_info(4'h5, 48'h111111_ABCDEF, 12'h123, 13'h0AA, 10'd2, 16'd3);
    drain();
    check_out(64'h4444_0000_0000_0010, 2);
    @(posedge CLK); #1;

    // Length errors
    for (int i = 0; i < 3; i++) begin
      send(mk_hdr(4'h7, 24'h0, bad_len[i]));
      @(negedge CLK);
      chk($sformatf("err_len_%0d", bad_len[i]), {ERR_LEN, ERR_NO_HEADER, oVALID}, 3'b100);
      @(posedge CLK); #1;
    end
    chk("len_err_no_out", 65'(outq.size()), 0);

    // Garbage before header (also proves the length errors left the parser idle)
    for (int i = 0; i < 3; i++) begin
      send(junk[i]);
      @(negedge CLK);
      chk($sformatf("err_no_hdr_%0d", i), {ERR_NO_HEADER, ERR_LEN, oVALID}, 3'b100);
      @(posedge CLK); #1;
    end

    // Max-length frame
    send_frame(mk_hdr(4'h9, 24'h000001, 10'd200), 64'h5555_0000_0000_1000, 200,
               mk_ftr(12'hFFF, 13'h0000, 24'hABCDEF, 8'h0F));
    expect_info(4'h9, 48'hABCDEF_000001, 12'hFFF, 13'h0000, 10'd200, 16'd4);
    drain();
    check_out(64'h5555_0000_0000_1000, 200);
    @(posedge CLK); #1;

    // Reset mid-frame after two data words
    send(mk_hdr(4'h2, 24'h222222, 10'd4));
    send(64'h6666_0000_0000_0000);
    send(64'h6666_0000_0000_0001);
    RESETN = 1'b0;
    @(negedge CLK);
    chk("mid_rst_oready", oREADY, 0);
    @(posedge CLK); #1;
    RESETN = 1'b1;
    @(negedge CLK);
    check_reset_vals();
    chk("mid_rst_words", 65'(outq.size()), 1);
    outq.delete();
    @(posedge CLK); #1;
    send_frame(mk_hdr(4'h2, 24'h222222, 10'd4), 64'h7777_0000_0000_0000, 4, ftr_nom);
    expect_info(4'h2, 48'h654321_222222, 12'hABC, 13'h1FFF, 10'd4, 16'd1);
    drain();
    check_out(64'h7777_0000_0000_0000, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_frame_parser.md
# data_frame_parser

Receive-side counterpart of the data frame generator. It consumes the 64-bit framed stream (header word, N ADC data words, footer word) on a valid/ready handshake. It forwards the data words downstream with a last-word marker and decodes header and footer fields into a per-frame info bundle. Malformed frames are detected and reported, and the parser resynchronises on the next header. It sits on the readout side of the trigger path, for example ahead of a DMA packer or as the checker in the frame-generator testbench.

## Interface
Parameters
- DOUT_WIDTH, 64, stream word width; fixed at 64.
- MAX_FRAME_LENGTH, 200, maximum data words per frame; the effective limit is rounded down to even.
- FRAME_LEN_WIDTH, 10, width of the frame-length field in header bits [FRAME_LEN_WIDTH-1:0].
- FRAME_CNT_WIDTH, 16, width of the good-frame counter.

Ports
- CLK, in, 1, single clock.
- RESETN, in, 1, reset, synchronous, active-low.
- iVALID, in, 1, upstream word valid.
- DIN, in, 64, upstream frame word.
- oREADY, out, 1, upstream ready; a word is accepted when iVALID & oREADY.
- oVALID, out, 1, data word valid toward downstream.
- DOUT, out, 64, data word toward downstream.
- DOUT_LAST, out, 1, marks the last data word of a frame; qualified by oVALID.
- iREADY, in, 1, downstream ready; a data word transfers when oVALID & iREADY.
- INFO_VALID, out, 1, one-cycle pulse when a good frame completes.
- CH_ID, out, 4, header[55:52].
- TIME_STAMP, out, 48, {footer[31:8], header[51:28]}.
- BASELINE, out, 12, footer[59:48].
- THRESHOLD, out, 13, footer[44:32].
- FRAME_LEN, out, FRAME_LEN_WIDTH, data-word count of the frame.
- ERR_NO_HEADER, ERR_LEN, ERR_FOOTER, out, 1 each, one-cycle error pulses.
- FRAME_CNT, out, FRAME_CNT_WIDTH, count of good frames; wraps.

## Operation
- States: IDLE, DATA, FOOTER.
- IDLE:
  - An accepted word with DIN[63:56]==8'hFF is a header.
  - The parser latches ch_id, first time stamp (header[51:28]) and length L = DIN[FRAME_LEN_WIDTH-1:0].
  - If L is valid, the next state is DATA and the remaining-word counter is set to L.
  - L is valid iff L != 0, L is even, and L ≤ 2*(MAX_FRAME_LENGTH/2).
  - If L is invalid, ERR_LEN pulses and the state stays IDLE.
  - Any other accepted word is dropped, ERR_NO_HEADER pulses, and the state stays IDLE.
- DATA:
  - Each accepted word is loaded into the output register and the counter decrements.
  - The word taken when the counter equals 1 carries DOUT_LAST=1, and the state moves to FOOTER.
  - Data words are not inspected for ID bytes.
- FOOTER: an accepted word is a good footer iff all of the following hold:
  - DIN[7:0]==8'h0F
  - DIN[63:60]==4'hF
  - DIN[47:45]==3'b111
- Good footer: the info outputs are updated, INFO_VALID pulses, FRAME_CNT increments, and the state returns to IDLE.
- Bad footer: ERR_FOOTER pulses, the info outputs and FRAME_CNT are unchanged, and the state returns to IDLE. Data words already forwarded are not recalled.
- oREADY:
  - Always 1 in IDLE and FOOTER.
  - In DATA, oREADY = ~oVALID | iREADY (a single output register, no bubble under continuous iREADY).
  - Always 0 while RESETN=0.
- FRAME_CNT wraps from all-ones to 0.

## Timing
- Reset values:
  - oVALID=0, DOUT_LAST=0, DOUT=64'hFFFF_FFFF_FFFF_FFFF.
  - INFO_VALID=0, all ERR_*=0.
  - CH_ID, TIME_STAMP, BASELINE, THRESHOLD, FRAME_LEN = 0.
  - FRAME_CNT=0, state=IDLE.
- Header accepted at cycle t: the state is DATA at t+1; the first data word can be accepted at t+1.
- Data word accepted at cycle k: DOUT/oVALID are valid at k+1. oVALID holds with stable DOUT until the cycle with iREADY=1. Simultaneous drain and load in one cycle is allowed.
- Footer accepted at cycle f:
  - INFO_VALID (or ERR_FOOTER) is high for exactly cycle f+1.
  - The info outputs and FRAME_CNT change at f+1 and hold until the next good frame.
- ERR_NO_HEADER and ERR_LEN pulse at the cycle after the offending word is accepted.
- The footer can be accepted while the last data word still awaits iREADY. The last word stays pending, and the next header can be accepted.
- Reset mid-frame: state returns to IDLE, the pending output word is discarded, and no INFO_VALID or ERR pulse is generated.

## Test plan
- Nominal frame:
  - Stimulus: header FF_3_123456_… with L=4, then data D0..D3, then footer F_ABC_E_1FFF_654321_0F, with iREADY=1.
  - Required: 4 words out; DOUT_LAST only on D3; INFO_VALID one cycle; CH_ID=3, TIME_STAMP=48'h654321_123456, BASELINE=12'hABC, THRESHOLD=13'h1FFF, FRAME_LEN=4; FRAME_CNT=1.
- Backpressure: same frame with iREADY toggling 1,0,0,1,…; no word lost or duplicated, DOUT stable while stalled, and oREADY=0 whenever oVALID=1 and iREADY=0.
- Bad footer: L=2 frame with footer low byte 8'h0E; 2 words out, ERR_FOOTER pulses once, FRAME_CNT unchanged, and a following good frame parses correctly.
- Length errors: headers with L=0, L=3 and L=202 each give ERR_LEN, no data output, state stays IDLE.
- Garbage before header: 3 words with DIN[63:56]!=FF before a good frame give 3 ERR_NO_HEADER pulses, then normal parsing; a max frame with L=200 outputs 200 words.
- Reset mid-frame: RESETN=0 for one cycle after 2 of 4 data words; all outputs return to reset values, and the next complete frame parses with FRAME_CNT=1.
